// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store controller.
//   lsu_state_e : controller FSM states
//   F3_*        : RV32 load/store funct3 encodings
package lsu_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_RESP
   } lsu_state_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_ctrl_if.sv
// Bus bundle around the load/store controller.
//   in_*   : EXU -> controller access request (valid/ready)
//   mem_*  : controller -> data memory request, memory -> controller response
//   out_*  : controller -> WBU result (valid/ready)
// Modports: slave = the controller, master = the surrounding core/memory.
interface lsu_ctrl_if;

   logic        in_valid;
   logic        in_ready;
   logic        in_is_store;
   logic [2:0]  in_funct3;
   logic [31:0] in_addr;
   logic [31:0] in_wdata;

   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_req_wen;
   logic [31:0] mem_req_wdata;
   logic [3:0]  mem_req_wmask;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_rdata;

   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_rdata;
   logic        out_err;

   modport slave (
      input  in_valid, in_is_store, in_funct3, in_addr, in_wdata,
      output in_ready,
      output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
      input  mem_req_ready, mem_resp_valid, mem_resp_rdata,
      output out_valid, out_rdata, out_err,
      input  out_ready
   );

   modport master (
      output in_valid, in_is_store, in_funct3, in_addr, in_wdata,
      input  in_ready,
      input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
      output mem_req_ready, mem_resp_valid, mem_resp_rdata,
      input  out_valid, out_rdata, out_err,
      output out_ready
   );

endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane logic for the load/store controller.
//   st_* : incoming access -> store byte mask, lane-replicated store data,
//          and the misaligned / illegal-funct3 flag
//   ld_* : latched access + memory word -> extended load result
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  st_funct3,
   input  logic [1:0]  st_off,
   input  logic        st_is_store,
   input  logic [31:0] st_wdata,
   output logic [3:0]  st_wmask,
   output logic [31:0] st_wdata_al,
   output logic        bad,
   input  logic [2:0]  ld_funct3,
   input  logic [1:0]  ld_off,
   input  logic [31:0] ld_rdata,
   output logic [31:0] ld_result
);

   logic [31:0] sh;

   // Unsigned funct3 variants only exist for loads; a store using them is illegal.
   always_comb begin
      bad         = 1'b0;
      st_wmask    = 4'b0000;
      st_wdata_al = st_wdata;
      case (st_funct3)
         F3_B: begin
            st_wmask    = 4'b0001 << st_off;
            st_wdata_al = {4{st_wdata[7:0]}};
         end
         F3_H: begin
            bad         = st_off[0];
            st_wmask    = 4'b0011 << st_off;
            st_wdata_al = {2{st_wdata[15:0]}};
         end
         F3_W: begin
            bad      = |st_off;
            st_wmask = 4'b1111;
         end
         F3_BU:   bad = st_is_store;
         F3_HU:   bad = st_is_store | st_off[0];
         default: bad = 1'b1;
      endcase
   end

   assign sh = ld_rdata >> {ld_off, 3'b000};

   always_comb begin
      ld_result = '0;
      case (ld_funct3)
         F3_B:    ld_result = {{24{sh[7]}}, sh[7:0]};
         F3_BU:   ld_result = {24'b0, sh[7:0]};
         F3_H:    ld_result = {{16{sh[15]}}, sh[15:0]};
         F3_HU:   ld_result = {16'b0, sh[15:0]};
         F3_W:    ld_result = sh;
         default: ld_result = '0;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: accepts one access from EXU, issues a single
// data-memory request, waits for the response (with an optional watchdog)
// and returns extended load data / store completion to WBU.
//   clk, rst : core clock, synchronous active-high reset
//   bus      : lsu_ctrl_if.slave (in_*, mem_*, out_* groups)
// TIMEOUT = max WAIT cycles before aborting with out_err (0 disables);
// TIMEOUT must fit in CNT_W bits.
module lsu_ctrl
   import lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned CNT_W   = 8
) (
   input  logic      clk,
   input  logic      rst,
   lsu_ctrl_if.slave bus
);

   localparam logic [CNT_W:0] TO_LIM = (CNT_W+1)'(TIMEOUT);

   lsu_state_e     state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W:0] cnt_inc;

   logic        lat_store;
   logic [2:0]  lat_f3;
   logic [1:0]  lat_off;

   logic        in_ready_q;
   logic        req_valid_q, req_wen_q;
   logic [31:0] req_addr_q, req_wdata_q;
   logic [3:0]  req_wmask_q;
   logic        out_valid_q, out_err_q;
   logic [31:0] out_rdata_q;

   logic [3:0]  st_wmask;
   logic [31:0] st_wdata_al, ld_result;
   logic        bad;

   lsu_align u_align (
      .st_funct3   (bus.in_funct3),
      .st_off      (bus.in_addr[1:0]),
      .st_is_store (bus.in_is_store),
      .st_wdata    (bus.in_wdata),
      .st_wmask    (st_wmask),
      .st_wdata_al (st_wdata_al),
      .bad         (bad),
      .ld_funct3   (lat_f3),
      .ld_off      (lat_off),
      .ld_rdata    (bus.mem_resp_rdata),
      .ld_result   (ld_result)
   );

   // cnt_inc is the value cnt takes this cycle; hitting TIMEOUT here means
   // WAIT has lasted exactly TIMEOUT cycles.
   assign cnt_inc = {1'b0, cnt} + (CNT_W+1)'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         cnt         <= '0;
         lat_store   <= 1'b0;
         lat_f3      <= '0;
         lat_off     <= '0;
         in_ready_q  <= 1'b1;
         req_valid_q <= 1'b0;
         req_wen_q   <= 1'b0;
         req_addr_q  <= '0;
         req_wdata_q <= '0;
         req_wmask_q <= '0;
         out_valid_q <= 1'b0;
         out_err_q   <= 1'b0;
         out_rdata_q <= '0;
      end else begin
         case (state)
            S_IDLE: if (bus.in_valid) begin
               lat_store  <= bus.in_is_store;
               lat_f3     <= bus.in_funct3;
               lat_off    <= bus.in_addr[1:0];
               in_ready_q <= 1'b0;
               if (bad) begin
                  // Rejected without touching memory.
                  state       <= S_RESP;
                  out_valid_q <= 1'b1;
                  out_err_q   <= 1'b1;
                  out_rdata_q <= '0;
               end else begin
                  state       <= S_REQ;
                  req_valid_q <= 1'b1;
                  req_addr_q  <= {bus.in_addr[31:2], 2'b00};
                  req_wen_q   <= bus.in_is_store;
                  req_wdata_q <= bus.in_is_store ? st_wdata_al : '0;
                  req_wmask_q <= bus.in_is_store ? st_wmask : 4'b0000;
               end
            end
            // Responses during REQ (including the handshake cycle) are ignored.
            S_REQ: if (bus.mem_req_ready) begin
               req_valid_q <= 1'b0;
               cnt         <= '0;
               state       <= S_WAIT;
            end
            S_WAIT: begin
               cnt <= cnt_inc[CNT_W-1:0];
               // A response wins over a watchdog expiry in the same cycle.
               if (bus.mem_resp_valid) begin
                  state       <= S_RESP;
                  out_valid_q <= 1'b1;
                  out_err_q   <= 1'b0;
                  out_rdata_q <= lat_store ? '0 : ld_result;
               end else if (TIMEOUT != 0 && cnt_inc == TO_LIM) begin
                  state       <= S_RESP;
                  out_valid_q <= 1'b1;
                  out_err_q   <= 1'b1;
                  out_rdata_q <= '0;
               end
            end
            S_RESP: if (bus.out_ready) begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state       <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.in_ready      = in_ready_q;
   assign bus.mem_req_valid = req_valid_q;
   assign bus.mem_req_addr  = req_addr_q;
   assign bus.mem_req_wen   = req_wen_q;
   assign bus.mem_req_wdata = req_wdata_q;
   assign bus.mem_req_wmask = req_wmask_q;
   assign bus.out_valid     = out_valid_q;
   assign bus.out_rdata     = out_rdata_q;
   assign bus.out_err       = out_err_q;

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store controller that sequences each data-memory access for the NPC core.
- Accepts one load or store from EXU over a valid/ready handshake and issues a single request to the data-memory port.
- Waits a variable number of cycles for the memory response, then returns extended load data or store completion to WBU.
- Also owns store byte-mask generation, lane alignment, misalignment detection and a response-timeout watchdog.

Parameters:
- TIMEOUT, 255, maximum cycles spent in WAIT before the access is aborted with out_err=1; 0 disables the watchdog.
- CNT_W, 8, width of the watchdog counter; TIMEOUT must be at most 2^CNT_W-1.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  EXU presents an access
- in_ready  out  1  controller can accept an access
- in_is_store  in  1  1 = store, 0 = load
- in_funct3  in  3  RV32 funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu
- in_addr  in  32  byte address
- in_wdata  in  32  store data, right-justified
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts the request
- mem_req_addr  out  32  word-aligned address, in_addr with bits [1:0] cleared
- mem_req_wen  out  1  write request
- mem_req_wdata  out  32  lane-shifted store data
- mem_req_wmask  out  4  byte strobes
- mem_resp_valid  in  1  response present, single-cycle pulse
- mem_resp_rdata  in  32  full word read
- out_valid  out  1  result available to WBU
- out_ready  in  1  WBU accepts the result
- out_rdata  out  32  extended load data; 0 for stores and errors
- out_err  out  1  access was misaligned, used an illegal funct3, or timed out

Behaviour:
- FSM states: IDLE, REQ, WAIT, RESP.
- Reset: state=IDLE; every output is 0 except in_ready=1; the watchdog counter is 0.
- in_ready=1 only in IDLE.
- IDLE, on in_valid: latch is_store, funct3, addr[1:0], address, wdata.
  - Misaligned access (h/hu with addr[0]=1, or w with addr[1:0]!=0) or illegal funct3: go to RESP with out_err=1 and out_rdata=0. No memory request is issued.
  - Otherwise go to REQ.
- REQ:
  - mem_req_valid=1. addr, wen, wdata and wmask are held stable until mem_req_ready=1.
  - On the handshake cycle go to WAIT and clear the counter.
  - A mem_resp_valid in the same cycle as the handshake is ignored; the earliest legal response is the cycle after the handshake.
- Store mask and data:
  - b: wmask = 4'b0001 << addr[1:0]; wdata = wdata[7:0] replicated 4 times.
  - h: wmask = 4'b0011 << addr[1:0]; wdata = wdata[15:0] replicated 2 times.
  - w: wmask = 4'b1111; wdata unchanged.
  - For loads, wmask=0 and wen=0.
- WAIT:
  - The counter increments each cycle.
  - On mem_resp_valid: compute the result and go to RESP with out_err=0.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT with no response: go to RESP with out_err=1, out_rdata=0. A late response is then discarded; the memory model guarantees at most one response per request.
- Load extension (store results give out_rdata=0):
  - Shift mem_resp_rdata right by 8*addr[1:0] to get the shifted word sh.
  - b: {24{sh[7]}, sh[7:0]}
  - bu: {24'b0, sh[7:0]}
  - h: {16{sh[15]}, sh[15:0]}
  - hu: {16'b0, sh[15:0]}
  - w: sh
- RESP:
  - out_valid=1; out_rdata and out_err are registered and held until out_ready=1, then go to IDLE.
  - Latency: an access can be accepted in the cycle after out_ready; there is no back-to-back bypass.
- Simultaneous events:
  - mem_resp_valid arriving in the same cycle the counter hits TIMEOUT counts as a valid response.
- Reset mid-operation:
  - rst asserted in any state returns to IDLE next cycle and drops mem_req_valid and out_valid.
  - The memory model must discard outstanding requests on reset.

Decomposition:
- Shared package lsu_pkg:
  - FSM state enum.
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
- Sub-module lsu_align (combinational):
  - Store side: wmask and wdata from funct3, addr[1:0], wdata.
  - Load side: extended result from funct3, addr[1:0], rdata.
  - Misalignment/illegal-funct3 flag.
- The FSM and the watchdog counter stay in lsu_ctrl.

Test Plan:
- lb at addr 0x80000003; memory returns 0x8A000000 two cycles after the request handshake -> mem_req_addr=0x80000000, mem_req_wmask=0, out_rdata=0xFFFFFF8A, out_err=0.
- sh at addr 0x80000002, wdata 0x1234ABCD, mem_req_ready held low 3 cycles -> mem_req_valid, addr, wdata and wmask stay stable for all 3 cycles; wdata=0xABCDABCD, wmask=4'b1100; after the response, out_valid=1, out_rdata=0, out_err=0.
- lw at addr 0x80000006 -> no mem_req_valid; out_valid the cycle after acceptance with out_err=1, out_rdata=0.
- lhu at 0x80000000, no response for TIMEOUT cycles -> out_err=1 exactly TIMEOUT cycles after entering WAIT; a late mem_resp_valid is ignored and in_ready returns to 1.
- out_ready held low 4 cycles in RESP -> out_valid, out_rdata and out_err stay stable; in_ready stays 0 until out_ready rises.
- rst asserted while in WAIT -> next cycle in_ready=1, mem_req_valid=0, out_valid=0; a new lbu to 0x80000001 with rdata 0x0000F000 returns 0x000000F0.
